sram_port_arbiter: RTL
======================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: BANK, default 2'b00, upper two bits driven on memAddrBus[17:16] for every access.
REQ-002 Port list, in this order:
 clk  in  1  system clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 aReq  in  1  port A (instruction fetch) read request
 aAddr  in  16  port A word address
 aAck  out  1  port A completion pulse
 aData  out  16  port A read data
 bReq  in  1  port B (data) request
 bWe  in  1  port B write enable (1 = write, 0 = read)
 bAddr  in  16  port B word address
 bWdata  in  16  port B write data
 bAck  out  1  port B completion pulse
 bData  out  16  port B read data
 memDataBus  inout  16  external SRAM data bus
 memAddrBus  out  18  external SRAM address, {BANK, granted address}
 memRead  out  1  SRAM output enable, active-low
 memWrite  out  1  SRAM write strobe, active-low
 memEnable  out  1  SRAM chip enable, active-low

Function
REQ-003 Requester SHALL hold req, addr, we and wdata stable from req assertion until it samples its ack high; arbiter SHALL NOT re-sample them after grant.
REQ-004 FSM states: IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD; all outputs registered.
REQ-005 In IDLE a port is eligible when its req is high and its ack output is low in that cycle (prevents double grant in ack cycle).
REQ-006 Arbitration round-robin via 1-bit lastGrant: only one eligible -> grant it; both eligible -> grant the port not equal to lastGrant; lastGrant updated on every grant.
REQ-007 Grant of A, or of B with bWe=0 -> RD_SETUP; grant of B with bWe=1 -> WR_SETUP.
REQ-008 RD_SETUP: memAddrBus={BANK,addr}, memEnable=0, memRead=0, memWrite=1, memDataBus hi-Z; next state RD_SAMPLE.
REQ-009 RD_SAMPLE: same drive as RD_SETUP; at its ending edge memDataBus captured into granted port's data register, ack of granted port set to 1, next state IDLE.
REQ-010 WR_SETUP: address driven, memEnable=0, memRead=1, memWrite=1, memDataBus driven with bWdata; next WR_PULSE.
REQ-011 WR_PULSE: as WR_SETUP but memWrite=0; next WR_HOLD.
REQ-012 WR_HOLD: memWrite=1, address and data still driven, memEnable=0; at ending edge bAck set to 1, next IDLE.
REQ-013 Latency: req first sampled eligible at edge N -> read ack high in cycle N+3, write ack high in cycle N+4 (counted in cycles after edge N); ack width exactly one cycle.
REQ-014 IDLE with no grant: memEnable=1, memRead=1, memWrite=1, memDataBus hi-Z, memAddrBus holds last value.
REQ-015 memDataBus SHALL be driven only in WR_SETUP, WR_PULSE, WR_HOLD; never while memRead=0.
REQ-016 aData/bData hold their last captured value until next read completion on that port; write completion on B does not alter bData.
REQ-017 req dropped after grant: transaction completes, ack still pulses; req dropped before grant: no access.
REQ-018 Back-to-back: one IDLE cycle minimum between transactions; sustained dual requests alternate A,B,A,B.
REQ-019 Address width rule: 16-bit addr zero-extended by BANK prefix only; no wrap or offset arithmetic.

Reset
REQ-020 rst high at a rising edge: state=IDLE, memEnable=1, memRead=1, memWrite=1, memDataBus hi-Z, memAddrBus=0, aAck=bAck=0, aData=bData=0, lastGrant=B (A wins first tie).
REQ-021 rst mid-transaction aborts it with no ack; a write aborted in WR_PULSE deasserts memWrite at that same reset edge.

Verification
REQ-022 Reset then aReq=1, aAddr=16'h0010, SRAM model word 0x0010=16'hBEEF -> memAddrBus=18'h00010, memRead low 2 cycles, aAck high cycle N+3, aData=16'hBEEF.
REQ-023 bReq=1, bWe=1, bAddr=16'h1234, bWdata=16'h5A5A -> memWrite low exactly 1 cycle with bus=16'h5A5A throughout the 3 write cycles, bAck at N+4; subsequent B read of 16'h1234 returns 16'h5A5A.
REQ-024 aReq and bReq asserted same cycle after reset and held re-asserted -> grant order A,B,A,B; no port granted twice while other waits.
REQ-025 rst asserted in WR_PULSE -> next cycle memWrite=1, memEnable=1, bus hi-Z, no bAck; later requests served normally.
REQ-026 aReq held high continuously across its ack -> exactly one access per ack, one IDLE gap, aAck never high two consecutive cycles; bus checker: memDataBus never driven while memRead=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for one asynchronous SRAM: port A fetches instructions (read only), port B reads and writes data.
// Grants alternate when both ports contend, and every SRAM strobe, address and data drive is a register.
module sram_port_arbiter #(
    parameter logic [1:0] BANK = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aReq,
    input  logic [15:0] aAddr,
    output logic        aAck,
    output logic [15:0] aData,
    input  logic        bReq,
    input  logic        bWe,
    input  logic [15:0] bAddr,
    input  logic [15:0] bWdata,
    output logic        bAck,
    output logic [15:0] bData,
    inout  wire  [15:0] memDataBus,
    output logic [17:0] memAddrBus,
    output logic        memRead,
    output logic        memWrite,
    output logic        memEnable
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_SAMPLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t      state;
    logic        lastGrant;
    logic        grantB;
    logic        driveBus;
    logic [15:0] wrData;
    logic        aElig;
    logic        bElig;
    logic        pickB;

    // A port whose ack is high this cycle is still finishing its handshake and must not be granted again.
    always_comb begin
        aElig = aReq && !aAck;
        bElig = bReq && !bAck;
        pickB = bElig && (!aElig || !lastGrant);
    end

    assign memDataBus = driveBus ? wrData : 16'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            memEnable  <= 1'b1;
            memRead    <= 1'b1;
            memWrite   <= 1'b1;
            driveBus   <= 1'b0;
            memAddrBus <= '0;
            aAck       <= 1'b0;
            bAck       <= 1'b0;
            aData      <= '0;
            bData      <= '0;
            lastGrant  <= 1'b1;
            grantB     <= 1'b0;
        end else begin
            aAck <= 1'b0;
            bAck <= 1'b0;
            case (state)
                IDLE: begin
                    memEnable <= 1'b1;
                    memRead   <= 1'b1;
                    memWrite  <= 1'b1;
                    driveBus  <= 1'b0;
                    if (aElig || bElig) begin
                        grantB     <= pickB;
                        lastGrant  <= pickB;
                        memEnable  <= 1'b0;
                        memAddrBus <= {BANK, (pickB ? bAddr : aAddr)};
                        if (pickB && bWe) begin
                            wrData   <= bWdata;
                            driveBus <= 1'b1;
                            state    <= WR_SETUP;
                        end else begin
                            memRead <= 1'b0;
                            state   <= RD_SETUP;
                        end
                    end
                end
                RD_SETUP: begin
                    state <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    if (grantB) begin
                        bData <= memDataBus;
                        bAck  <= 1'b1;
                    end else begin
                        aData <= memDataBus;
                        aAck  <= 1'b1;
                    end
                    memEnable <= 1'b1;
                    memRead   <= 1'b1;
                    state     <= IDLE;
                end
                WR_SETUP: begin
                    memWrite <= 1'b0;
                    state    <= WR_PULSE;
                end
                WR_PULSE: begin
                    memWrite <= 1'b1;
                    state    <= WR_HOLD;
                end
                WR_HOLD: begin
                    bAck      <= 1'b1;
                    memEnable <= 1'b1;
                    driveBus  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    memEnable <= 1'b1;
                    memRead   <= 1'b1;
                    memWrite  <= 1'b1;
                    driveBus  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
